// File: rtl/shiftx_ift_out_fifo.sv
// Show-ahead output FIFO for the IFT shift-extract cell. It buffers each word
// together with its taint vector and tracks sticky taint and a saturating tainted-word count.
module shiftx_ift_out_fifo #(
  parameter int DATA_WIDTH  = 2,
  parameter int TAINT_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       CLK,
  input  logic                       ARST_N,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [DATA_WIDTH-1:0]      IN_DATA,
  input  logic [TAINT_WIDTH-1:0]     IN_DATA_t,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [DATA_WIDTH-1:0]      OUT_DATA,
  output logic [TAINT_WIDTH-1:0]     OUT_DATA_t,
  output logic [$clog2(DEPTH):0]     LEVEL,
  input  logic                       TAINT_CLR,
  output logic [TAINT_WIDTH-1:0]     TAINT_STICKY,
  output logic [CNT_WIDTH-1:0]       TAINTED_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
  logic [TAINT_WIDTH-1:0] taint_q [DEPTH];

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [TAINT_WIDTH-1:0] sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic push, pop, full, empty, in_tainted;

  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  // Ready is a pure function of registered occupancy, held low while in reset.
  assign IN_READY   = ARST_N & ~full;
  assign OUT_VALID  = ~empty;
  assign push       = IN_VALID & IN_READY;
  assign pop        = OUT_VALID & OUT_READY;
  assign in_tainted = |IN_DATA_t;

  // The head is masked so an empty buffer never reports stale data or taint.
  assign OUT_DATA     = empty ? '0 : data_q[rd_ptr_q];
  assign OUT_DATA_t   = empty ? '0 : taint_q[rd_ptr_q];
  assign LEVEL        = level_q;
  assign TAINT_STICKY = sticky_q;
  assign TAINTED_CNT  = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (TAINT_CLR) begin
      sticky_d = push ? IN_DATA_t : '0;
      cnt_d    = (push && in_tainted) ? CNT_WIDTH'(1) : '0;
    end else if (push) begin
      sticky_d = sticky_q | IN_DATA_t;
      if (in_tainted && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; emptiness masks whatever it holds.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr_q]  <= IN_DATA;
      taint_q[wr_ptr_q] <= IN_DATA_t;
    end
  end

endmodule

// File: tb/tb_shiftx_ift_out_fifo.sv
// Directed self-checking bench for shiftx_ift_out_fifo, built with a 4-bit
// tainted-word counter so saturation is reachable in a few cycles.
module tb_shiftx_ift_out_fifo;

  logic        CLK = 1'b0;
  logic        ARST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [1:0]  IN_DATA;
  logic [31:0] IN_DATA_t;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [1:0]  OUT_DATA;
  logic [31:0] OUT_DATA_t;
  logic [2:0]  LEVEL;
  logic        TAINT_CLR;
  logic [31:0] TAINT_STICKY;
  logic [3:0]  TAINTED_CNT;

  int vectors = 0;
  int miscompares = 0;

  logic [33:0] q[$];
  logic [33:0] head;

  shiftx_ift_out_fifo #(
    .DATA_WIDTH(2), .TAINT_WIDTH(32), .DEPTH(4), .CNT_WIDTH(4)
  ) dut (
    .CLK(CLK), .ARST_N(ARST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .IN_DATA_t(IN_DATA_t),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_DATA_t(OUT_DATA_t),
    .LEVEL(LEVEL), .TAINT_CLR(TAINT_CLR),
    .TAINT_STICKY(TAINT_STICKY), .TAINTED_CNT(TAINTED_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setInputs(input logic v, input logic [1:0] d, input logic [31:0] t,
                           input logic ordy, input logic clr);
    IN_VALID  = v;
    IN_DATA   = d;
    IN_DATA_t = t;
    OUT_READY = ordy;
    TAINT_CLR = clr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] d, input logic [31:0] t,
                               input logic ordy, input logic clr);
    setInputs(v, d, t, ordy, clr);
    tick();
  endtask

  initial begin
    ARST_N = 1'b0;
    setInputs(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_in_ready", {31'b0, IN_READY}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    checkOutput("rst_level", {29'b0, LEVEL}, 32'd0);
    tick();
    tick();
    ARST_N = 1'b1;
    #1;
    checkOutput("rel_in_ready", {31'b0, IN_READY}, 32'd1);
    checkOutput("rel_out_taint", OUT_DATA_t, 32'h0);

    // Fill to full with the consumer stalled.
    applyStimulus(1'b1, 2'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("first_visible", {31'b0, OUT_VALID}, 32'd1);
    applyStimulus(1'b1, 2'd1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 32'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 32'h8000_0000, 1'b0, 1'b0);
    checkOutput("full_level", {29'b0, LEVEL}, 32'd4);
    checkOutput("full_in_ready", {31'b0, IN_READY}, 32'd0);
    checkOutput("full_sticky", TAINT_STICKY, 32'h8000_0001);
    checkOutput("full_cnt", {28'b0, TAINTED_CNT}, 32'd2);

    // Refused fifth word, then refused again while a pop happens.
    applyStimulus(1'b1, 2'd1, 32'hFF, 1'b0, 1'b0);
    checkOutput("held_level", {29'b0, LEVEL}, 32'd4);
    checkOutput("held_sticky", TAINT_STICKY, 32'h8000_0001);
    setInputs(1'b1, 2'd1, 32'hFF, 1'b1, 1'b0);
    checkOutput("pop0_data", {30'b0, OUT_DATA}, 32'd0);
    checkOutput("pop0_taint", OUT_DATA_t, 32'h0);
    tick();
    checkOutput("full_pop_level", {29'b0, LEVEL}, 32'd3);
    checkOutput("refused_sticky", TAINT_STICKY, 32'h8000_0001);
    checkOutput("refused_cnt", {28'b0, TAINTED_CNT}, 32'd2);
    setInputs(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop1_data", {30'b0, OUT_DATA}, 32'd1);
    checkOutput("pop1_taint", OUT_DATA_t, 32'h0);
    tick();
    checkOutput("pop2_data", {30'b0, OUT_DATA}, 32'd2);
    checkOutput("pop2_taint", OUT_DATA_t, 32'h1);
    tick();
    checkOutput("pop3_data", {30'b0, OUT_DATA}, 32'd3);
    checkOutput("pop3_taint", OUT_DATA_t, 32'h8000_0000);
    tick();
    checkOutput("drain_level", {29'b0, LEVEL}, 32'd0);
    checkOutput("drain_valid", {31'b0, OUT_VALID}, 32'd0);
    checkOutput("empty_data", {30'b0, OUT_DATA}, 32'd0);
    checkOutput("empty_taint", OUT_DATA_t, 32'h0);

    // Streaming at level 2 across the pointer wrap.
    q.delete();
    applyStimulus(1'b1, 2'd2, 32'h40, 1'b0, 1'b0);
    q.push_back({2'd2, 32'h40});
    applyStimulus(1'b1, 2'd3, 32'h80, 1'b0, 1'b0);
    q.push_back({2'd3, 32'h80});
    for (int i = 0; i < 6; i++) begin
      setInputs(1'b1, 2'(i), 32'h100 << i, 1'b1, 1'b0);
      head = q.pop_front();
      checkOutput($sformatf("stream%0d_data", i), {30'b0, OUT_DATA}, {30'b0, head[33:32]});
      checkOutput($sformatf("stream%0d_taint", i), OUT_DATA_t, head[31:0]);
      q.push_back({2'(i), 32'h100 << i});
      tick();
      checkOutput($sformatf("stream%0d_level", i), {29'b0, LEVEL}, 32'd2);
    end
    setInputs(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      head = q.pop_front();
      checkOutput($sformatf("tail%0d_data", i), {30'b0, OUT_DATA}, {30'b0, head[33:32]});
      checkOutput($sformatf("tail%0d_taint", i), OUT_DATA_t, head[31:0]);
      tick();
    end
    checkOutput("stream_end_level", {29'b0, LEVEL}, 32'd0);

    // Sticky taint, clear, clear-with-accept.
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    checkOutput("clr_sticky", TAINT_STICKY, 32'h0);
    checkOutput("clr_cnt", {28'b0, TAINTED_CNT}, 32'd0);
    applyStimulus(1'b1, 2'd1, 32'h3, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd2, 32'h10, 1'b1, 1'b0);
    checkOutput("sticky_or", TAINT_STICKY, 32'h13);
    checkOutput("sticky_cnt", {28'b0, TAINTED_CNT}, 32'd2);
    applyStimulus(1'b1, 2'd3, 32'h4, 1'b1, 1'b1);
    checkOutput("clr_acc_sticky", TAINT_STICKY, 32'h4);
    checkOutput("clr_acc_cnt", {28'b0, TAINTED_CNT}, 32'd1);
    applyStimulus(1'b1, 2'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("clean_word_cnt", {28'b0, TAINTED_CNT}, 32'd1);
    checkOutput("clean_word_sticky", TAINT_STICKY, 32'h4);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'd1, 32'h1, 1'b1, 1'b0);
    checkOutput("sat_cnt", {28'b0, TAINTED_CNT}, 32'd15);
    applyStimulus(1'b1, 2'd2, 32'h0, 1'b1, 1'b0);
    checkOutput("sat_clean_cnt", {28'b0, TAINTED_CNT}, 32'd15);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("sat_drained", {29'b0, LEVEL}, 32'd0);

    // Refused word at a non-saturated count, then head stability under backpressure.
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 32'h20, 1'b0, 1'b0);
    checkOutput("refused2_cnt", {28'b0, TAINTED_CNT}, 32'd0);
    checkOutput("refused2_sticky", TAINT_STICKY, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      checkOutput($sformatf("stall%0d_data", i), {30'b0, OUT_DATA}, 32'd1);
      checkOutput($sformatf("stall%0d_valid", i), {31'b0, OUT_VALID}, 32'd1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("stall_drained", {29'b0, LEVEL}, 32'd0);

    // Asynchronous reset with three entries held.
    applyStimulus(1'b1, 2'd1, 32'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 32'h6, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 32'h7, 1'b0, 1'b0);
    setInputs(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("pre_rst_level", {29'b0, LEVEL}, 32'd3);
    #2;
    ARST_N = 1'b0;
    #1;
    checkOutput("arst_valid", {31'b0, OUT_VALID}, 32'd0);
    checkOutput("arst_level", {29'b0, LEVEL}, 32'd0);
    checkOutput("arst_sticky", TAINT_STICKY, 32'h0);
    checkOutput("arst_cnt", {28'b0, TAINTED_CNT}, 32'd0);
    #10;
    ARST_N = 1'b1;
    #1;
    checkOutput("rerel_in_ready", {31'b0, IN_READY}, 32'd1);
    checkOutput("rerel_taint", OUT_DATA_t, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
